// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the multicycle add/subtract unit.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  // A bad CHUNK is reported by the top level; return 1 here to avoid dividing by zero.
  function automatic int nchunk(input int width, input int chunk);
    return (chunk < 1) ? 1 : width / chunk;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple of full-adder cells covering one CHUNK-bit slice.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// Add/subtract unit resolving one CHUNK-bit slice per clock, with valid/ready on both sides.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if (CHUNK < 1) begin : g_chunk_check
    $error("multicycle_adder: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  state_t           state_next;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic             accept;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;

  assign slice_a = a_reg[idx*CHUNK +: CHUNK];
  assign slice_b = b_reg[idx*CHUNK +: CHUNK];
  assign accept  = in_valid && in_ready;

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (slice_a),
    .b     (slice_b),
    .cin   (carry),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (idx == LAST) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is a + ~b + ~borrow, so operands are conditioned once at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= sub ? ~b : b;
      carry <= sub ? ~cin : cin;
      idx   <= '0;
    end else if (state == RUN) begin
      sum[idx*CHUNK +: CHUNK] <= slice_sum;
      carry                   <= slice_cout;
      if (idx == LAST) begin
        cout     <= slice_cout;
        overflow <= slice_cout ^ slice_cmsb;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder: a 16/4 instance and an 8/8 single-cycle instance.
module tb_multicycle_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        in_valid16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0, out_ready16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready16, out_valid16, cout16, ovf16;
  logic [15:0] sum16;

  logic        in_valid8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, cout8, ovf8;
  logic [7:0]  sum8;

  bit   rand_ready16 = 1'b0, rand_ready8 = 1'b0;
  exp_t q16[$];
  exp_t q8[$];
  bit   seen16 = 1'b0, seen8 = 1'b0;

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .cout(cout16), .overflow(ovf16)
  );

  multicycle_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
    exp_t   e;
    longint m  = longint'(1) << w;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint c  = longint'(cin);
    longint sa = a[w-1] ? ua - m : ua;
    longint sb = b[w-1] ? ub - m : ub;
    longint r, sr;
    if (!sub) begin
      r      = ua + ub + c;
      sr     = sa + sb + c;
      e.cout = (r >= m);
    end else begin
      r      = ua - ub - c;
      sr     = sa - sb - c;
      e.cout = (ua >= ub + c);
    end
    e.sum     = 16'(r & (m - 1));
    e.ovf     = (sr < -(m / 2)) || (sr >= m / 2);
    e.acc_cyc = 0;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rand_ready16) out_ready16 = 1'($urandom_range(0, 1));
    if (rand_ready8)  out_ready8  = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rst_n && out_valid16) begin
      if (q16.size() == 0) begin
        check("unexpected_valid16", {31'b0, out_valid16}, 32'd0);
      end else begin
        if (!seen16) begin
          check("latency16", 32'(cyc - q16[0].acc_cyc), 32'd4);
          seen16 = 1'b1;
        end
        check("result16", {14'b0, cout16, ovf16, sum16},
              {14'b0, q16[0].cout, q16[0].ovf, q16[0].sum});
        if (out_ready16) begin
          void'(q16.pop_front());
          seen16 = 1'b0;
        end else begin
          check("hold_in_ready16", {31'b0, in_ready16}, 32'd0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid8) begin
      if (q8.size() == 0) begin
        check("unexpected_valid8", {31'b0, out_valid8}, 32'd0);
      end else begin
        if (!seen8) begin
          check("latency8", 32'(cyc - q8[0].acc_cyc), 32'd1);
          seen8 = 1'b1;
        end
        check("result8", {22'b0, cout8, ovf8, sum8},
              {22'b0, q8[0].cout, q8[0].ovf, q8[0].sum[7:0]});
        if (out_ready8) begin
          void'(q8.pop_front());
          seen8 = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic apply_stimulus(input bit w8, input logic [15:0] a, input logic [15:0] b,
                                input logic cin, input logic sub);
    exp_t e;
    if (w8) begin
      in_valid8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub;
    end else begin
      in_valid16 = 1'b1; a16 = a; b16 = b; cin16 = cin; sub16 = sub;
    end
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (w8 ? in_ready8 : in_ready16) begin
        e = model(w8 ? 8 : 16, w8 ? {8'b0, a[7:0]} : a, w8 ? {8'b0, b[7:0]} : b, cin, sub);
        e.acc_cyc = cyc + 1;
        if (w8) q8.push_back(e);
        else    q16.push_back(e);
        step();
        // Scramble operands after accept; the unit must ignore them.
        if (w8) begin
          in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = ~sub8;
        end else begin
          in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sub16 = ~sub16;
        end
        return;
      end
      step();
    end
    checks++;
    errors++;
    $display("[TB] FAIL accept_timeout: actual=no in_ready required=in_ready within 100 cycles");
    in_valid8  = 1'b0;
    in_valid16 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 300; t++) begin
      if (q16.size() == 0 && q8.size() == 0) return;
      step();
    end
    checks++;
    errors++;
    $display("[TB] FAIL drain_timeout: actual=%0d/%0d pending required=0/0", q16.size(), q8.size());
  endtask

  task automatic check_output(input string tag);
    check({tag, "_out_valid16"}, {31'b0, out_valid16}, 32'd0);
    check({tag, "_in_ready16"},  {31'b0, in_ready16},  32'd1);
    check({tag, "_out_valid8"},  {31'b0, out_valid8},  32'd0);
    check({tag, "_in_ready8"},   {31'b0, in_ready8},   32'd1);
  endtask

  initial begin
    #12;
    check_output("reset");
    check("reset_result16", {14'b0, cout16, ovf16, sum16}, 32'd0);
    check("reset_result8",  {22'b0, cout8, ovf8, sum8},    32'd0);
    step();
    rst_n = 1'b1;
    out_ready16 = 1'b1;
    out_ready8  = 1'b1;
    step();

    apply_stimulus(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    apply_stimulus(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    apply_stimulus(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    apply_stimulus(0, 16'h0005, 16'h0007, 1'b0, 1'b1);
    apply_stimulus(0, 16'h8000, 16'h0001, 1'b0, 1'b1);
    apply_stimulus(0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    wait_drain();

    // Back-pressure for three cycles, then retire and accept on the same edge.
    out_ready16 = 1'b0;
    apply_stimulus(0, 16'hABCD, 16'h1111, 1'b1, 1'b0);
    for (int t = 0; t < 20 && !out_valid16; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    step();
    out_ready16 = 1'b1;
    apply_stimulus(0, 16'h4000, 16'h4000, 1'b0, 1'b0);
    wait_drain();

    // Reset while idx==2 discards the operation.
    apply_stimulus(0, 16'h2222, 16'h3333, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrun_out_valid16", {31'b0, out_valid16}, 32'd0);
    check("midrun_in_ready16",  {31'b0, in_ready16},  32'd1);
    q16.delete();
    seen16 = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (8) step();
    check("post_reset_out_valid16", {31'b0, out_valid16}, 32'd0);

    apply_stimulus(1, 16'h0080, 16'h0080, 1'b0, 1'b0);
    apply_stimulus(1, 16'h007F, 16'h0001, 1'b0, 1'b0);
    apply_stimulus(1, 16'h0080, 16'h0001, 1'b0, 1'b1);
    wait_drain();

    rand_ready16 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      apply_stimulus(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) step();
    end
    rand_ready16 = 1'b0;
    out_ready16  = 1'b1;
    wait_drain();

    rand_ready8 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      apply_stimulus(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    rand_ready8 = 1'b0;
    out_ready8  = 1'b1;
    wait_drain();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
